// File: rtl/i2c_init_sequencer_if.sv
// Command type and handshake bundle between the init sequencer and the I2C
// wrapper FIFOs (command push, write-byte push, read-byte pop).
// Ports: master = sequencer side, slave = wrapper FIFO side.
package i2c_init_sequencer_pkg;
  typedef struct packed {
    logic        we;          // 1 = write transfer, 0 = read transfer
    logic        sccb_mode;   // SCCB framing select for the wrapper
    logic [6:0]  addr_slave;  // 7-bit slave address
    logic [15:0] addr_reg;    // register address, zero-extended from 8 bits
    logic [7:0]  burst_num;   // extra bytes beyond the first (always 0 here)
  } t_i2c_cmd;
endpackage

interface i2c_init_sequencer_if;
  import i2c_init_sequencer_pkg::*;

  t_i2c_cmd    o_cmd_data;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic [7:0]  o_wr_data;
  logic        o_wr_valid;
  logic        i_wr_ready;
  logic [7:0]  i_rd_data;
  logic        i_rd_valid;
  logic        o_rd_ready;

  modport master (
    output o_cmd_valid, o_cmd_data, input i_cmd_ready,
    output o_wr_valid, o_wr_data, input i_wr_ready,
    input  i_rd_valid, i_rd_data, output o_rd_ready
  );

  modport slave (
    input  o_cmd_valid, o_cmd_data, output i_cmd_ready,
    input  o_wr_valid, o_wr_data, output i_wr_ready,
    output i_rd_valid, i_rd_data, input o_rd_ready
  );
endinterface

// File: rtl/i2c_init_sequencer.sv
// Walks a ROM table of WRITE / DELAY / VERIFY / END entries and feeds the I2C
// wrapper FIFOs. Latency: 2 cycles fetch+decode per entry plus handshakes.
// Backpressure: each valid holds its data until the matching ready is seen.
// Ports: i_clk, i_rst (sync, active-high), i_start pulse; o_busy/o_done/o_error
// status with o_error_code/o_error_index; o_rom_addr/i_rom_data table port
// (1-cycle read latency); if_bus carries the cmd/wr/rd FIFO handshakes.
module i2c_init_sequencer
  import i2c_init_sequencer_pkg::*;
#(
  parameter int ROM_AW         = 8,
  parameter int DELAY_UNIT     = 25_000,
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int SCCB_MODE      = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_error_code,
  output logic [ROM_AW-1:0] o_error_index,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  i2c_init_sequencer_if.master if_bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_PUSH_WR  = 4'd3;
  localparam logic [3:0] S_PUSH_CMD = 4'd4;
  localparam logic [3:0] S_WAIT_RD  = 4'd5;
  localparam logic [3:0] S_DELAY    = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_ERROR    = 4'd8;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_DELAY  = 2'b01;
  localparam logic [1:0] OP_VERIFY = 2'b10;

  localparam logic [1:0] ERR_VERIFY  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  logic [3:0]        r_state;
  logic [ROM_AW-1:0] r_addr;
  logic [1:0]        r_op;
  logic [6:0]        r_slave;
  logic [7:0]        r_reg;
  logic [7:0]        r_data;
  logic [31:0]       r_cnt;
  logic [1:0]        r_err_code;
  logic [ROM_AW-1:0] r_err_index;

  logic [1:0]  w_rom_op;
  logic [31:0] w_delay_total;
  logic        w_advance;
  t_i2c_cmd    w_cmd;

  assign w_rom_op      = i_rom_data[31:30];
  assign w_delay_total = 32'(i_rom_data[15:0]) * 32'(DELAY_UNIT);

  // Entry finished successfully this cycle; the address step (or overrun
  // abort) is handled once, after the per-state logic.
  always_comb begin
    w_advance = 1'b0;
    case (r_state)
      S_PUSH_CMD: w_advance = if_bus.i_cmd_ready && (r_op != OP_VERIFY);
      S_WAIT_RD:  w_advance = if_bus.i_rd_valid && (if_bus.i_rd_data == r_data);
      S_DELAY:    w_advance = (r_cnt == '0);
      default:    w_advance = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_op        <= '0;
      r_slave     <= '0;
      r_reg       <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_err_code  <= '0;
      r_err_index <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_state    <= S_FETCH;
            r_addr     <= '0;
            r_err_code <= '0;
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_op    <= w_rom_op;
          r_slave <= i_rom_data[29:23];
          r_reg   <= i_rom_data[22:15];
          r_data  <= i_rom_data[7:0];
          case (w_rom_op)
            OP_WRITE:  r_state <= S_PUSH_WR;
            OP_VERIFY: r_state <= S_PUSH_CMD;
            OP_DELAY: begin
              // Decode counts as the first delay cycle and the FETCH that
              // follows as the last, so DELAY itself lasts total-1 cycles
              // (minimum 1).
              r_state <= S_DELAY;
              r_cnt   <= (w_delay_total > 32'd1) ? w_delay_total - 32'd2 : 32'd0;
            end
            default:   r_state <= S_DONE;
          endcase
        end
        S_PUSH_WR: if (if_bus.i_wr_ready) r_state <= S_PUSH_CMD;
        S_PUSH_CMD: begin
          if (if_bus.i_cmd_ready && (r_op == OP_VERIFY)) begin
            r_state <= S_WAIT_RD;
            r_cnt   <= 32'(TIMEOUT_CYCLES - 1);
          end
        end
        S_WAIT_RD: begin
          if (if_bus.i_rd_valid) begin
            if (if_bus.i_rd_data != r_data) begin
              r_state     <= S_ERROR;
              r_err_code  <= ERR_VERIFY;
              r_err_index <= r_addr;
            end
          end else if (r_cnt == '0) begin
            r_state     <= S_ERROR;
            r_err_code  <= ERR_TIMEOUT;
            r_err_index <= r_addr;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_DELAY: if (r_cnt != '0) r_cnt <= r_cnt - 32'd1;
        default: r_state <= S_IDLE;
      endcase

      if (w_advance) begin
        // The table never wraps: stepping past the last entry is an error.
        if (&r_addr) begin
          r_state     <= S_ERROR;
          r_err_code  <= ERR_OVERRUN;
          r_err_index <= r_addr;
        end else begin
          r_addr  <= r_addr + ROM_AW'(1);
          r_state <= S_FETCH;
        end
      end
    end
  end

  // Command fields are forced to zero outside PUSH_CMD so nothing leaks out
  // of reset or idle.
  always_comb begin
    w_cmd = '0;
    if (r_state == S_PUSH_CMD) begin
      w_cmd.we         = (r_op == OP_WRITE);
      w_cmd.sccb_mode  = (SCCB_MODE != 0);
      w_cmd.addr_slave = r_slave;
      w_cmd.addr_reg   = {8'h00, r_reg};
      w_cmd.burst_num  = 8'h00;
    end
  end

  assign if_bus.o_cmd_valid = (r_state == S_PUSH_CMD);
  assign if_bus.o_cmd_data  = w_cmd;
  assign if_bus.o_wr_valid  = (r_state == S_PUSH_WR);
  assign if_bus.o_wr_data   = (r_state == S_PUSH_WR) ? r_data : 8'h00;
  assign if_bus.o_rd_ready  = (r_state == S_WAIT_RD);

  assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign o_done        = (r_state == S_DONE);
  assign o_error       = (r_state == S_ERROR);
  assign o_error_code  = r_err_code;
  assign o_error_index = r_err_index;
  assign o_rom_addr    = r_addr;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: ROM model, FIFO-side responders and a
// scoreboard of expected write bytes and commands, plus timing checks.
module tb_i2c_init_sequencer;
  import i2c_init_sequencer_pkg::*;

  localparam int AW   = 2;
  localparam int UNIT = 10;
  localparam int TMO  = 100;
  localparam int SCCB = 1;
  localparam logic [31:0] ENTRY_END = 32'hC000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, error;
  logic [1:0]    ecode;
  logic [AW-1:0] eidx, rom_addr;
  logic [31:0]   rom_data;

  i2c_init_sequencer_if bus();

  i2c_init_sequencer #(
    .ROM_AW(AW), .DELAY_UNIT(UNIT), .TIMEOUT_CYCLES(TMO), .SCCB_MODE(SCCB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done), .o_error(error),
    .o_error_code(ecode), .o_error_index(eidx),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .if_bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0]   rom [4];
  logic [AW-1:0] rom_addr_q;
  logic [7:0]    rd_q[$];
  logic [7:0]    exp_wr[$];
  t_i2c_cmd      exp_cmd[$];
  logic          cmd_stall;
  int unsigned   cyc;
  int            n_cmp, n_bad;
  int            n_wr_hs, n_cmd_hs, n_rd_hs, n_rd_done, wr_pend;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_write(input logic [6:0] s, input logic [7:0] r, input logic [7:0] d);
    return {2'b00, s, r, 7'b0, d};
  endfunction
  function automatic logic [31:0] mk_verify(input logic [6:0] s, input logic [7:0] r, input logic [7:0] d);
    return {2'b10, s, r, 7'b0, d};
  endfunction
  function automatic logic [31:0] mk_delay(input logic [15:0] c);
    return {2'b01, 14'b0, c};
  endfunction
  function automatic t_i2c_cmd mk_cmd(input logic we, input logic [6:0] s, input logic [7:0] r);
    t_i2c_cmd c;
    c            = '0;
    c.we         = we;
    c.sccb_mode  = (SCCB != 0);
    c.addr_slave = s;
    c.addr_reg   = {8'h00, r};
    c.burst_num  = 8'h00;
    return c;
  endfunction

  function automatic logic [63:0] outs_vec();
    return 64'({busy, done, error, ecode, eidx, rom_addr, bus.o_cmd_valid, bus.o_cmd_data,
                bus.o_wr_valid, bus.o_wr_data, bus.o_rd_ready});
  endfunction

  task automatic load(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(done || error), 64'd1);
  endtask

  // FIFO-side responders and registered ROM, updated just after each edge.
  initial begin
    bus.i_cmd_ready = 1'b1;
    bus.i_wr_ready  = 1'b0;
    bus.i_rd_valid  = 1'b0;
    bus.i_rd_data   = 8'h00;
    rom_data        = 32'h0;
    cyc             = 0;
    n_rd_done       = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      rom_data = rom[rom_addr_q];
      while (n_rd_done < n_rd_hs) begin
        if (rd_q.size() != 0) rd_q.delete(0);
        n_rd_done++;
      end
      bus.i_rd_valid  = (rd_q.size() != 0);
      bus.i_rd_data   = (rd_q.size() != 0) ? rd_q[0] : 8'h00;
      bus.i_cmd_ready = !cmd_stall;
      bus.i_wr_ready  = cyc[1];
    end
  end

  // Handshake monitor: checks pushes against the scoreboard.
  initial begin
    n_wr_hs = 0; n_cmd_hs = 0; n_rd_hs = 0; wr_pend = 0;
    forever begin
      @(negedge clk);
      rom_addr_q = rom_addr;
      if (rst) wr_pend = 0;
      if (bus.o_wr_valid && bus.i_wr_ready) begin
        n_wr_hs++;
        wr_pend++;
        chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          chk("wr_dat", 64'(bus.o_wr_data), 64'(exp_wr[0]));
          exp_wr.delete(0);
        end
      end
      if (bus.o_cmd_valid && bus.i_cmd_ready) begin
        n_cmd_hs++;
        chk("cmd_expected", 64'(exp_cmd.size() != 0), 64'd1);
        if (exp_cmd.size() != 0) begin
          chk("cmd_dat", 64'(bus.o_cmd_data), 64'(exp_cmd[0]));
          exp_cmd.delete(0);
        end
        if (bus.o_cmd_data.we) begin
          chk("wr_before_cmd", 64'(wr_pend), 64'd1);
          wr_pend = 0;
        end
      end
      if (bus.o_rd_ready && bus.i_rd_valid) n_rd_hs++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, nw, stable, hs0, r0;
    t_i2c_cmd exp_c;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; cmd_stall = 1'b0;
    load(ENTRY_END, ENTRY_END, ENTRY_END, ENTRY_END);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs_vec(), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // single WRITE then END; a stale read byte must stay untouched
    load(mk_write(7'h21, 8'h0A, 8'h55), ENTRY_END, ENTRY_END, ENTRY_END);
    exp_wr.push_back(8'h55);
    exp_cmd.push_back(mk_cmd(1'b1, 7'h21, 8'h0A));
    rd_q.push_back(8'h77);
    pulse_start();
    wait_end("a_finish", 200);
    chk("a_done", 64'(done), 64'd1);
    chk("a_busy", 64'(busy), 64'd0);
    chk("a_error", 64'(error), 64'd0);
    chk("a_stale_kept", 64'(rd_q.size()), 64'd1);
    rd_q.delete();

    // command stalled for 50 cycles
    exp_c = mk_cmd(1'b1, 7'h21, 8'h0A);
    exp_wr.push_back(8'h55);
    exp_cmd.push_back(exp_c);
    cmd_stall = 1'b1;
    hs0 = n_cmd_hs;
    pulse_start();
    n = 0;
    while (!bus.o_cmd_valid && n < 50) begin @(negedge clk); n++; end
    stable = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.o_cmd_valid && (bus.o_cmd_data == exp_c) && (n_cmd_hs == hs0)) stable++;
      @(negedge clk);
    end
    chk("b_stall_stable", 64'(stable), 64'd50);
    cmd_stall = 1'b0;
    wait_end("b_finish", 200);
    chk("b_one_cmd", 64'(n_cmd_hs - hs0), 64'd1);
    chk("b_done", 64'(done), 64'd1);

    // VERIFY match, byte already waiting in the read FIFO
    load(mk_verify(7'h33, 8'h00, 8'hA5), ENTRY_END, ENTRY_END, ENTRY_END);
    exp_cmd.push_back(mk_cmd(1'b0, 7'h33, 8'h00));
    rd_q.push_back(8'hA5);
    r0 = n_rd_hs;
    pulse_start();
    wait_end("c_finish", 200);
    chk("c_done", 64'(done), 64'd1);
    chk("c_error", 64'(error), 64'd0);
    chk("c_rd_pops", 64'(n_rd_hs - r0), 64'd1);

    // VERIFY mismatch
    exp_cmd.push_back(mk_cmd(1'b0, 7'h33, 8'h00));
    rd_q.push_back(8'h5A);
    pulse_start();
    wait_end("c2_finish", 200);
    chk("c2_error", 64'(error), 64'd1);
    chk("c2_done", 64'(done), 64'd0);
    chk("c2_code", 64'(ecode), 64'd1);
    chk("c2_index", 64'(eidx), 64'd0);

    // mismatch on the second entry
    load(mk_write(7'h10, 8'h01, 8'h11), mk_verify(7'h10, 8'h01, 8'h22), ENTRY_END, ENTRY_END);
    exp_wr.push_back(8'h11);
    exp_cmd.push_back(mk_cmd(1'b1, 7'h10, 8'h01));
    exp_cmd.push_back(mk_cmd(1'b0, 7'h10, 8'h01));
    rd_q.push_back(8'h23);
    pulse_start();
    wait_end("c3_finish", 200);
    chk("c3_code", 64'(ecode), 64'd1);
    chk("c3_index", 64'(eidx), 64'd1);

    // read timeout: WAIT_RD to ERROR in exactly TMO cycles
    load(mk_verify(7'h44, 8'h12, 8'h99), ENTRY_END, ENTRY_END, ENTRY_END);
    exp_cmd.push_back(mk_cmd(1'b0, 7'h44, 8'h12));
    pulse_start();
    n = 0;
    @(negedge clk);
    while (!bus.o_rd_ready && n < 50) begin @(negedge clk); n++; end
    nw = n;
    while (!error && n < 400) begin @(negedge clk); n++; end
    chk("d_timeout_cycles", 64'(n - nw), 64'(TMO));
    chk("d_code", 64'(ecode), 64'd2);
    chk("d_index", 64'(eidx), 64'd0);
    chk("d_rd_rdy_low", 64'(bus.o_rd_ready), 64'd0);

    // DELAY 3: FETCH at n=0, DECODE at n=1, next FETCH 30 cycles later
    load(mk_delay(16'd3), ENTRY_END, ENTRY_END, ENTRY_END);
    pulse_start();
    n = 0;
    @(negedge clk);
    while (rom_addr != 2'd1 && n < 200) begin @(negedge clk); n++; end
    chk("e_delay3_cycles", 64'(n), 64'd31);
    wait_end("e_finish", 50);
    chk("e_done", 64'(done), 64'd1);

    // DELAY 0 spends a single cycle in DELAY
    load(mk_delay(16'd0), ENTRY_END, ENTRY_END, ENTRY_END);
    pulse_start();
    n = 0;
    @(negedge clk);
    while (rom_addr != 2'd1 && n < 200) begin @(negedge clk); n++; end
    chk("e_delay0_cycles", 64'(n), 64'd3);
    wait_end("e0_finish", 50);

    // table overrun, reset, and rerun from address 0
    load(mk_write(7'h50, 8'h00, 8'hC0), mk_write(7'h51, 8'h01, 8'hC1),
         mk_write(7'h52, 8'h02, 8'hC2), mk_write(7'h53, 8'h03, 8'hC3));
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back(8'(8'hC0 + i));
      exp_cmd.push_back(mk_cmd(1'b1, 7'(7'h50 + i), 8'(i)));
    end
    pulse_start();
    wait_end("f_finish", 400);
    chk("f_error", 64'(error), 64'd1);
    chk("f_code", 64'(ecode), 64'd3);
    chk("f_index", 64'(eidx), 64'd3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("f_reset_outputs", outs_vec(), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back(8'(8'hC0 + i));
      exp_cmd.push_back(mk_cmd(1'b1, 7'(7'h50 + i), 8'(i)));
    end
    pulse_start();
    wait_end("f2_finish", 400);
    chk("f2_code", 64'(ecode), 64'd3);
    chk("f2_index", 64'(eidx), 64'd3);

    // reset in the middle of a stalled command handshake
    load(mk_write(7'h2A, 8'h3B, 8'h4C), ENTRY_END, ENTRY_END, ENTRY_END);
    exp_wr.push_back(8'h4C);
    exp_cmd.push_back(mk_cmd(1'b1, 7'h2A, 8'h3B));
    cmd_stall = 1'b1;
    pulse_start();
    n = 0;
    while (!bus.o_cmd_valid && n < 50) begin @(negedge clk); n++; end
    chk("g_cmd_vld_pre_rst", 64'(bus.o_cmd_valid), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("g_reset_outputs", outs_vec(), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    cmd_stall = 1'b0;
    exp_cmd.delete();
    hs0 = n_cmd_hs;
    repeat (10) @(negedge clk);
    chk("g_no_resume_busy", 64'(busy), 64'd0);
    chk("g_no_resume_cmd", 64'(n_cmd_hs - hs0), 64'd0);

    chk("sb_wr_empty", 64'(exp_wr.size()), 64'd0);
    chk("sb_cmd_empty", 64'(exp_cmd.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_init_sequencer.md
I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 SHALL have parameter ROM_AW, default 8: table address width, so depth is 2**ROM_AW entries.
REQ-002 SHALL have parameter DELAY_UNIT, default 25_000: clock cycles per delay tick (1 ms at 25 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2_500_000: maximum wait for read data (100 ms).
REQ-004 SHALL have parameter SCCB_MODE, default 0: value driven on the command sccb_mode field.
REQ-005 i_clk  in  1  the single clock; all logic on the rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_start  in  1  single-cycle pulse; begins the table run.
REQ-008 o_busy  out  1  high from accepted start until DONE or ERROR.
REQ-009 o_done  out  1  level; the table completed without error.
REQ-010 o_error  out  1  level; the run aborted.
REQ-011 o_error_code  out  2  01 verify mismatch, 10 read timeout, 11 table overrun, 00 none.
REQ-012 o_error_index  out  ROM_AW  table address of the failing entry.
REQ-013 o_rom_addr  out  ROM_AW  table address; i_rom_data is valid exactly 1 cycle later.
REQ-014 i_rom_data  in  32  table entry.
REQ-015 o_cmd_valid / o_cmd_data (t_i2c_cmd) / i_cmd_ready  out/out/in: command push into the wrapper command FIFO.
REQ-016 o_wr_valid / o_wr_data[7:0] / i_wr_ready  out/out/in: write-byte push into the wrapper write FIFO.
REQ-017 i_rd_valid / i_rd_data[7:0] / o_rd_ready  in/in/out: read-byte pop from the wrapper read FIFO.

Function
REQ-018 Entry format SHALL be: [31:30] op; [29:23] slave; [22:15] reg; [7:0] data; [15:0] delay count (DELAY op only).
REQ-019 Ops SHALL be: 00 WRITE, 01 DELAY, 10 VERIFY (read 1 byte and compare), 11 END.
REQ-020 States SHALL be IDLE, FETCH, DECODE, PUSH_WR, PUSH_CMD, WAIT_RD, DELAY, DONE, ERROR.
REQ-021 Start SHALL be accepted in IDLE, DONE or ERROR; accepting it clears o_done, o_error and o_error_code, sets address to 0 and enters FETCH; start SHALL be ignored in any other state.
REQ-022 FETCH SHALL drive o_rom_addr for 1 cycle, then go to DECODE, which registers i_rom_data.
REQ-023 WRITE SHALL go to PUSH_WR, hold o_wr_valid with data until i_wr_ready, then go to PUSH_CMD.
REQ-024 In PUSH_CMD for a WRITE entry, o_cmd_data SHALL carry: we=1, sccb_mode=SCCB_MODE, addr_slave=slave, addr_reg=reg (zero-extended), burst_num=0.
REQ-025 For a VERIFY entry, o_cmd_data SHALL carry the same fields with we=0.
REQ-026 o_cmd_valid SHALL stay high with stable data until i_cmd_ready; the write byte SHALL always be pushed before its command.
REQ-027 After the command handshake, a WRITE entry SHALL increment the address and go to FETCH; a VERIFY entry SHALL go to WAIT_RD.
REQ-028 WAIT_RD SHALL hold o_rd_ready=1.
REQ-029 In WAIT_RD, on i_rd_valid: if i_rd_data == data, increment the address and go to FETCH; otherwise go to ERROR with code 01.
REQ-030 WAIT_RD SHALL go to ERROR with code 10 after TIMEOUT_CYCLES cycles without i_rd_valid.
REQ-031 DELAY SHALL wait count*DELAY_UNIT cycles, then increment the address and go to FETCH; count 0 SHALL advance after 1 cycle.
REQ-032 The delay SHALL start at decode and SHALL NOT wait for queued commands to finish on the bus.
REQ-033 END SHALL go to DONE.
REQ-034 Advancing past address 2**ROM_AW-1 SHALL NOT wrap; it SHALL go to ERROR with code 11 and index 2**ROM_AW-1.
REQ-035 o_error_index SHALL latch the current address on entry to ERROR.
REQ-036 o_rd_ready SHALL be 0 outside WAIT_RD.
REQ-037 Stale read bytes SHALL NOT be consumed outside WAIT_RD.

Reset
REQ-038 On i_rst: state IDLE and address 0.
REQ-039 On i_rst, every output SHALL be 0: valids, o_rd_ready, o_busy, o_done, o_error, o_error_code, o_error_index, o_rom_addr, o_cmd_data and o_wr_data.
REQ-040 Reset mid-handshake SHALL drop all valids on the next cycle.
REQ-041 A run interrupted by reset SHALL NOT resume; a new start is required.

Verification
REQ-042 Table {WRITE 0x21/0x0A/0x55, END}, start -> one wr push 0x55, then cmd {we=1, slave 0x21, reg 0x0A, burst 0}; o_done=1, o_busy=0.
REQ-043 i_cmd_ready held low 50 cycles during PUSH_CMD -> o_cmd_valid and data stable for all 50 cycles; exactly one command accepted.
REQ-044 Table {VERIFY 0x33/0x00/0xA5, END}, read returns 0xA5 -> o_done; returns 0x5A -> o_error, code 01, index 0.
REQ-045 VERIFY with no read data, TIMEOUT_CYCLES=100 -> ERROR with code 10 exactly 100 cycles after entering WAIT_RD.
REQ-046 DELAY count 3, DELAY_UNIT=10 -> next FETCH exactly 30 cycles after decode.
REQ-047 ROM_AW=2, all four entries WRITE -> error code 11, index 3; then i_rst -> all outputs 0; then a new start reruns from address 0.
